// File: rtl/lap_record_mem.sv
// Lap-record RAM (30 x 28 bit) with a stopwatch read/write port and a background byte-frame dump engine.
// Optional frame checksum byte is enabled by defining LAP_DUMP_CHECKSUM_EN.
module lap_record_mem #(
    parameter int         P_DEPTH = 30,
    parameter int         P_AW    = 5,
    parameter int         P_DW    = 28,
    parameter logic [7:0] P_SYNC  = 8'hA5
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iMemEn,
    input  logic            iMemWE,
    input  logic [P_AW-1:0] iMemAddr,
    input  logic [P_DW-1:0] iMemWData,
    output logic [P_DW-1:0] oMemRData,
    input  logic            iDumpReq,
    output logic            oDumpBusy,
    output logic            oTxValid,
    output logic [7:0]      oTxData,
    input  logic            iTxReady,
    output logic [5:0]      oRecordCount
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_COUNT = 3'd2,
        S_SCAN  = 3'd3,
        S_READ  = 3'd4,
`ifdef LAP_DUMP_CHECKSUM_EN
        S_BYTE  = 3'd5,
        S_SUM   = 3'd6
`else
        S_BYTE  = 3'd5
`endif
    } state_t;

    function automatic logic [5:0] popcount(input logic [P_DEPTH-1:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < P_DEPTH; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [7:0] rec_byte(input logic [P_DW-1:0] r, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = {1'b0, r[27:21]};
            2'd1:    b = {1'b0, r[20:14]};
            2'd2:    b = {1'b0, r[13:7]};
            default: b = {1'b0, r[6:0]};
        endcase
        return b;
    endfunction

    logic [P_DW-1:0]    mem_r [0:P_DEPTH-1];
    logic [P_DW-1:0]    rdata_r;
    logic [P_DW-1:0]    rd_b_r;
    logic [P_DEPTH-1:0] valid_r;
    logic [5:0]         count_r;
    logic               addr_ok_s;
    logic               xfer_s;
    logic               end_s;

    state_t             state_r, state_s;
    logic [P_AW-1:0]    idx_r, idx_s;
    logic [P_DEPTH-1:0] snap_r, snap_s;
    logic [5:0]         snap_cnt_r, snap_cnt_s;
    logic [1:0]         byte_r, byte_s;
    logic               tx_valid_r, tx_valid_s;
    logic [7:0]         tx_data_r, tx_data_s;
    logic               busy_r, busy_s;
`ifdef LAP_DUMP_CHECKSUM_EN
    logic [7:0]         sum_r, sum_s;
`endif

    assign addr_ok_s = (32'(iMemAddr) < 32'(P_DEPTH));
    assign xfer_s    = tx_valid_r & iTxReady;

    // Port A array write; the array itself is never reset
    always_ff @(posedge iClk) begin
        if (iMemEn && iMemWE && addr_ok_s) begin
            mem_r[iMemAddr] <= iMemWData;
        end
    end

    // Port B read-first read for the dump engine
    always_ff @(posedge iClk) begin
        if (state_r == S_READ) begin
            rd_b_r <= mem_r[idx_r];
        end
    end

    // Port A read data with write-through, valid bitmap and record count
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rdata_r <= {P_DW{1'b0}};
            valid_r <= {P_DEPTH{1'b0}};
            count_r <= 6'd0;
        end else begin
            count_r <= popcount(valid_r);
            if (iMemEn) begin
                if (!addr_ok_s) begin
                    rdata_r <= {P_DW{1'b0}};
                end else if (iMemWE) begin
                    rdata_r           <= iMemWData;
                    valid_r[iMemAddr] <= |iMemWData;
                end else begin
                    rdata_r <= mem_r[iMemAddr];
                end
            end
        end
    end

    // Dump FSM next-state and next-output logic
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        snap_s     = snap_r;
        snap_cnt_s = snap_cnt_r;
        byte_s     = byte_r;
        tx_valid_s = tx_valid_r;
        tx_data_s  = tx_data_r;
        busy_s     = busy_r;
        end_s      = 1'b0;
`ifdef LAP_DUMP_CHECKSUM_EN
        if (xfer_s) begin
            sum_s = sum_r ^ tx_data_r;
        end else begin
            sum_s = sum_r;
        end
`endif
        case (state_r)
            S_IDLE: begin
                if (iDumpReq) begin
                    snap_s     = valid_r;
                    snap_cnt_s = popcount(valid_r);
                    idx_s      = {P_AW{1'b0}};
                    state_s    = S_SYNC;
                    tx_valid_s = 1'b1;
                    tx_data_s  = P_SYNC;
                    busy_s     = 1'b1;
`ifdef LAP_DUMP_CHECKSUM_EN
                    sum_s      = 8'd0;
`endif
                end else begin
                    busy_s = 1'b0;
                end
            end
            S_SYNC: begin
                if (xfer_s) begin
                    state_s   = S_COUNT;
                    tx_data_s = {2'b00, snap_cnt_r};
                end else begin
                    state_s = S_SYNC;
                end
            end
            S_COUNT: begin
                if (xfer_s) begin
                    end_s      = (snap_r == {P_DEPTH{1'b0}});
                    state_s    = S_SCAN;
                    tx_valid_s = 1'b0;
                    idx_s      = {P_AW{1'b0}};
                end else begin
                    state_s = S_COUNT;
                end
            end
            S_SCAN: begin
                if (32'(idx_r) >= 32'(P_DEPTH)) begin
                    end_s = 1'b1;
                end else if (snap_r[idx_r]) begin
                    state_s = S_READ;
                end else if (32'(idx_r) == 32'(P_DEPTH - 1)) begin
                    end_s = 1'b1;
                end else begin
                    idx_s = idx_r + P_AW'(1);
                end
            end
            S_READ: begin
                // Retiring the bit here lets the last record byte know whether the frame ends
                snap_s[idx_r] = 1'b0;
                byte_s        = 2'd0;
                state_s       = S_BYTE;
            end
            S_BYTE: begin
                if (!tx_valid_r) begin
                    tx_valid_s = 1'b1;
                    tx_data_s  = rec_byte(rd_b_r, 2'd0);
                end else if (xfer_s) begin
                    if (byte_r == 2'd3) begin
                        end_s      = (snap_r == {P_DEPTH{1'b0}});
                        state_s    = S_SCAN;
                        tx_valid_s = 1'b0;
                        idx_s      = idx_r + P_AW'(1);
                    end else begin
                        byte_s    = byte_r + 2'd1;
                        tx_data_s = rec_byte(rd_b_r, byte_r + 2'd1);
                    end
                end else begin
                    state_s = S_BYTE;
                end
            end
`ifdef LAP_DUMP_CHECKSUM_EN
            S_SUM: begin
                if (xfer_s) begin
                    state_s    = S_IDLE;
                    tx_valid_s = 1'b0;
                    busy_s     = 1'b0;
                end else begin
                    state_s = S_SUM;
                end
            end
`endif
            default: begin
                state_s    = S_IDLE;
                tx_valid_s = 1'b0;
                busy_s     = 1'b0;
            end
        endcase
        if (end_s) begin
`ifdef LAP_DUMP_CHECKSUM_EN
            state_s    = S_SUM;
            tx_valid_s = 1'b1;
            tx_data_s  = sum_s;
`else
            state_s    = S_IDLE;
            tx_valid_s = 1'b0;
            busy_s     = 1'b0;
`endif
        end else begin
            end_s = 1'b0;
        end
    end

    // Dump FSM state and registered TX outputs
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_r    <= S_IDLE;
            idx_r      <= {P_AW{1'b0}};
            snap_r     <= {P_DEPTH{1'b0}};
            snap_cnt_r <= 6'd0;
            byte_r     <= 2'd0;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'd0;
            busy_r     <= 1'b0;
`ifdef LAP_DUMP_CHECKSUM_EN
            sum_r      <= 8'd0;
`endif
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            snap_r     <= snap_s;
            snap_cnt_r <= snap_cnt_s;
            byte_r     <= byte_s;
            tx_valid_r <= tx_valid_s;
            tx_data_r  <= tx_data_s;
            busy_r     <= busy_s;
`ifdef LAP_DUMP_CHECKSUM_EN
            sum_r      <= sum_s;
`endif
        end
    end

    assign oMemRData    = rdata_r;
    assign oRecordCount = count_r;
    assign oDumpBusy    = busy_r;
    assign oTxValid     = tx_valid_r;
    assign oTxData      = tx_data_r;

endmodule

// File: tb/tb_lap_record_mem.sv
// Self-checking bench for lap_record_mem: directed and randomized steps against a slot/bitmap reference model.
module tb_lap_record_mem;

    localparam logic [7:0] SYNC = 8'hA5;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iMemEn = 1'b0;
    logic        iMemWE = 1'b0;
    logic [4:0]  iMemAddr = 5'd0;
    logic [27:0] iMemWData = 28'd0;
    logic [27:0] oMemRData;
    logic        iDumpReq = 1'b0;
    logic        oDumpBusy;
    logic        oTxValid;
    logic [7:0]  oTxData;
    logic        iTxReady = 1'b1;
    logic [5:0]  oRecordCount;

    int checks = 0;
    int errors = 0;

    logic [27:0] mem_m [30];
    bit          valid_m [30];

    always #5 iClk = ~iClk;

    lap_record_mem dut (
        .iClk(iClk), .iRst(iRst),
        .iMemEn(iMemEn), .iMemWE(iMemWE), .iMemAddr(iMemAddr), .iMemWData(iMemWData),
        .oMemRData(oMemRData),
        .iDumpReq(iDumpReq), .oDumpBusy(oDumpBusy),
        .oTxValid(oTxValid), .oTxData(oTxData), .iTxReady(iTxReady),
        .oRecordCount(oRecordCount)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] mk_rec(input int h, input int m, input int s, input int c);
        return 28'(h * (1 << 21) + m * (1 << 14) + s * (1 << 7) + c);
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 30; i++) if (valid_m[i]) n++;
        return n;
    endfunction

    task automatic wr(input int a, input logic [27:0] d);
        iMemEn = 1'b1; iMemWE = 1'b1; iMemAddr = 5'(a); iMemWData = d;
        @(negedge iClk);
        iMemEn = 1'b0; iMemWE = 1'b0;
        if (a < 30) begin
            mem_m[a]   = d;
            valid_m[a] = (d != 28'd0);
        end
        check($sformatf("wr_through_a%0d", a), 32'(oMemRData), (a < 30) ? 32'(d) : 32'd0);
    endtask

    task automatic rd(input int a);
        iMemEn = 1'b1; iMemWE = 1'b0; iMemAddr = 5'(a);
        @(negedge iClk);
        iMemEn = 1'b0;
        check($sformatf("rd_a%0d", a), 32'(oMemRData), (a < 30) ? 32'(mem_m[a]) : 32'd0);
    endtask

    task automatic check_count();
        @(negedge iClk);
        check("record_count", 32'(oRecordCount), 32'(model_count()));
    endtask

    // Requests a dump and collects the frame; optional stall, random ready, extra request, reset abort.
    task automatic run_dump(input int stall_at, input int stall_len, input bit rnd,
                            input bit extra_req, input int abort_after);
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        logic [7:0] x;
        int n, stall, cyc;
        bit hold, quiet;
        logic [7:0] hold_d;
        exp_q.push_back(SYNC);
        exp_q.push_back(8'(model_count()));
        for (int i = 0; i < 30; i++) begin
            if (valid_m[i]) begin
                exp_q.push_back(8'((mem_m[i] >> 21) % 128));
                exp_q.push_back(8'((mem_m[i] >> 14) % 128));
                exp_q.push_back(8'((mem_m[i] >> 7) % 128));
                exp_q.push_back(8'(mem_m[i] % 128));
            end
        end
`ifdef LAP_DUMP_CHECKSUM_EN
        x = 8'd0;
        foreach (exp_q[k]) x = x ^ exp_q[k];
        exp_q.push_back(x);
`else
        x = 8'd0;
`endif
        iDumpReq = 1'b1;
        @(negedge iClk);
        iDumpReq = 1'b0;
        check("req_valid", 32'(oTxValid), 32'd1);
        check("req_data", 32'(oTxData), 32'(SYNC));
        check("req_busy", 32'(oDumpBusy), 32'd1);
        n = 0; stall = 0; cyc = 0; hold = 1'b0; hold_d = 8'd0;
        while (n < exp_q.size() && cyc < 2000) begin
            if (hold) begin
                check("hold_valid", 32'(oTxValid), 32'd1);
                check("hold_data", 32'(oTxData), 32'(hold_d));
            end
            if (n == stall_at && oTxValid && stall < stall_len) begin
                iTxReady = 1'b0;
                stall++;
                check("stall_byte", 32'(oTxData), 32'(exp_q[n]));
            end else begin
                iTxReady = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            iDumpReq = (extra_req && n == 4) ? 1'b1 : 1'b0;
            hold   = oTxValid && !iTxReady;
            hold_d = oTxData;
            if (oTxValid && iTxReady) begin
                got_q.push_back(oTxData);
                n++;
            end
            @(negedge iClk);
            cyc++;
            if (abort_after > 0 && n >= abort_after) break;
        end
        iTxReady = 1'b1;
        iDumpReq = 1'b0;
        check("dump_timeout", 32'(cyc < 2000), 32'd1);
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            check($sformatf("frame_byte%0d", k), 32'(got_q[k]), 32'(exp_q[k]));
        end
        if (abort_after > 0) begin
            iRst = 1'b1;
            #1;
            check("abort_valid", 32'(oTxValid), 32'd0);
            check("abort_busy", 32'(oDumpBusy), 32'd0);
            check("abort_data", 32'(oTxData), 32'd0);
            check("abort_count", 32'(oRecordCount), 32'd0);
            check("abort_len", 32'(got_q.size()), 32'(abort_after));
            @(negedge iClk);
            iRst = 1'b0;
            for (int i = 0; i < 30; i++) valid_m[i] = 1'b0;
        end else begin
            check("frame_len", 32'(got_q.size()), 32'(exp_q.size()));
            check("busy_end", 32'(oDumpBusy), 32'd0);
            check("valid_end", 32'(oTxValid), 32'd0);
        end
        quiet = 1'b1;
        repeat (12) begin
            @(negedge iClk);
            if (oTxValid || oDumpBusy) quiet = 1'b0;
        end
        check("quiet_after_frame", 32'(quiet), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge iClk);
        check("rst_rdata", 32'(oMemRData), 32'd0);
        check("rst_valid", 32'(oTxValid), 32'd0);
        check("rst_data", 32'(oTxData), 32'd0);
        check("rst_busy", 32'(oDumpBusy), 32'd0);
        check("rst_count", 32'(oRecordCount), 32'd0);
        iRst = 1'b0;
        @(negedge iClk);

        for (int a = 0; a < 30; a++) wr(a, 28'd0);
        check_count();

        // Port A write then read back
        wr(4, 28'h0A1B2C3);
        rd(4);
        check_count();

        // Two-record dump, then the same frame with a stall at the third byte
        wr(4, 28'd0);
        wr(0, mk_rec(1, 2, 3, 4));
        wr(7, mk_rec(0, 59, 59, 99));
        check_count();
        run_dump(-1, 0, 1'b0, 1'b0, 0);
        run_dump(2, 5, 1'b0, 1'b0, 0);

        // Out-of-range addresses and a request while busy
        wr(30, 28'h1234567);
        rd(30);
        wr(31, 28'h0000001);
        rd(31);
        check_count();
        run_dump(-1, 0, 1'b0, 1'b1, 0);

        // Random traffic with random backpressure
        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < 8; w++) begin
                if ($urandom_range(0, 3) == 0) wr($urandom_range(0, 29), 28'd0);
                else wr($urandom_range(0, 29), mk_rec($urandom_range(0, 23), $urandom_range(0, 59),
                                                      $urandom_range(0, 59), $urandom_range(0, 99)));
            end
            for (int k = 0; k < 4; k++) rd($urandom_range(0, 31));
            check_count();
            run_dump(-1, 0, 1'b1, 1'b0, 0);
        end

        // Clear sequence empties the bitmap
        wr(1, mk_rec(0, 1, 2, 3));
        wr(2, mk_rec(0, 4, 5, 6));
        wr(3, mk_rec(0, 7, 8, 9));
        for (int a = 0; a < 30; a++) wr(a, 28'd0);
        check_count();
        run_dump(-1, 0, 1'b0, 1'b0, 0);

        // Reset mid-frame, array survives, fresh frame afterwards
        wr(5, mk_rec(12, 34, 56, 78));
        wr(29, mk_rec(23, 59, 59, 99));
        check_count();
        run_dump(-1, 0, 1'b0, 1'b0, 3);
        rd(29);
        check_count();
        wr(5, mk_rec(12, 34, 56, 78));
        wr(29, mk_rec(23, 59, 59, 99));
        check_count();
        run_dump(-1, 0, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
